// File: rtl/sipo_pkg.sv
// Shared helpers for the serial-in, parallel-out converter.
package sipo_pkg;

   // Bit-counter width for a word of n bits; never below one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Modulo-N bit counter; word_done_c flags the last bit of each word.
module sipo_bit_counter
   import sipo_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic clk,
   input  logic rst,
   output logic word_done_c
);

   localparam int unsigned CW = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic [CW-1:0] cnt;

   // Wrap to zero on the same edge the word register loads.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (word_done_c) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign word_done_c = (cnt == LAST);

endmodule

// File: rtl/sipo.sv
// Serial-in, parallel-out converter: MSB-first shift register plus a word register.
module sipo
   import sipo_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in,
   output logic [N-1:0] out,
   output logic [N-1:0] outP
);

   logic [N-1:0] sr;
   logic [N-1:0] wr;
   logic [N-1:0] sr_next_c;
   logic         word_done_c;

   sipo_bit_counter #(.N(N)) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .word_done_c (word_done_c)
   );

   assign sr_next_c = {sr[N-2:0], in};

   // The word register captures the same value the shift register takes on the final bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr <= '0;
         wr <= '0;
      end else begin
         sr <= sr_next_c;
         if (word_done_c) begin
            wr <= sr_next_c;
         end
      end
   end

   assign out  = sr;
   assign outP = wr;

endmodule

// File: tb/tb_sipo.sv
// Self-checking bench for sipo (N=8 and N=4) against a bit-history model.
module tb_sipo;

   logic       clk;
   logic       rst;
   logic       in;
   logic [7:0] out8;
   logic [7:0] outp8;
   logic [3:0] out4;
   logic [3:0] outp4;

   int total = 0;
   int bad   = 0;

   // Bits sampled since the last reset, oldest first.
   bit hist[$];

   sipo #(.N(8)) u8 (.clk(clk), .rst(rst), .in(in), .out(out8), .outP(outp8));
   sipo #(.N(4)) u4 (.clk(clk), .rst(rst), .in(in), .out(out4), .outP(outp4));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (rst) hist.delete();
      else     hist.push_back(in);
   end

   // Live register: the most recent n bits, newest in bit 0.
   function automatic logic [7:0] m_out(input int n);
      logic [7:0] v = '0;
      int s = hist.size();
      for (int i = 0; i < n && i < s; i++) v[i] = hist[s-1-i];
      return v;
   endfunction

   // Word register: the latest complete n-bit group, first bit in the MSB.
   function automatic logic [7:0] m_outp(input int n);
      logic [7:0] v = '0;
      int c = hist.size() / n;
      int base;
      if (c == 0) return v;
      base = (c - 1) * n;
      for (int i = 0; i < n; i++) v[n-1-i] = hist[base+i];
      return v;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("model_out8",  out8,          m_out(8));
      check("model_outp8", outp8,         m_outp(8));
      check("model_out4",  {4'h0, out4},  m_out(4));
      check("model_outp4", {4'h0, outp4}, m_outp(4));
   end

   // Drive one edge's inputs, then settle just after the edge.
   task automatic step(input logic b, input logic r);
      in  = b;
      rst = r;
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) step(w[i], 1'b0);
   endtask

   initial begin
      logic [7:0] w;
      rst = 1'b1;
      in  = 1'b0;

      step(1'b1, 1'b1);
      check("rst_out_a",  out8,  8'h00);
      check("rst_outp_a", outp8, 8'h00);
      step(1'b0, 1'b1);
      check("rst_out_b",  out8,  8'h00);
      check("rst_outp_b", outp8, 8'h00);

      // Alternating 1,0,1,0...
      for (int k = 1; k <= 16; k++) begin
         step((k % 2) == 1, 1'b0);
         if (k == 1) check("alt_out1", out8, 8'h01);
         if (k == 2) check("alt_out2", out8, 8'h02);
         if (k == 3) check("alt_out3", out8, 8'h05);
         if (k == 4) check("alt_out4", out8, 8'h0A);
         if (k == 7) check("alt_outp7", outp8, 8'h00);
         if (k >= 8) check("alt_outp", outp8, 8'hAA);
      end

      // Back-to-back words.
      step(1'b0, 1'b1);
      w = 8'hA5;
      for (int i = 7; i >= 0; i--) step(w[i], 1'b0);
      check("b2b_a5", outp8, 8'hA5);
      w = 8'h3C;
      for (int i = 7; i >= 1; i--) begin
         step(w[i], 1'b0);
         check("b2b_hold", outp8, 8'hA5);
      end
      step(w[0], 1'b0);
      check("b2b_3c", outp8, 8'h3C);

      // Mid-word reset after a full word is held.
      send_byte(8'h5A);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      check("mid_out0",  out8,  8'h00);
      check("mid_outp0", outp8, 8'h00);
      w = 8'h81;
      for (int i = 7; i >= 1; i--) step(w[i], 1'b0);
      check("mid_outp7", outp8, 8'h00);
      step(w[0], 1'b0);
      check("mid_outp8", outp8, 8'h81);

      // Constant ones.
      step(1'b0, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 1'b0);
         check("ones_out", out8, 8'((16'h1 << k) - 1));
         check("ones_outp", outp8, (k == 8) ? 8'hFF : 8'h00);
      end

      // Four-bit instance: 1101 then 0010.
      step(1'b0, 1'b1);
      w = 8'hD2;
      for (int i = 7; i >= 0; i--) begin
         step(w[i], 1'b0);
         if (i == 4) check("n4_d", {4'h0, outp4}, 8'h0D);
         if (i == 0) check("n4_2", {4'h0, outp4}, 8'h02);
      end

      // Random stream with occasional resets.
      for (int k = 0; k < 2000; k++) begin
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 3));
      end

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sipo.md
# sipo

Serial-in, parallel-out converter: a 1-bit serial stream is shifted into an N-bit register on every clock. After every N bits, the assembled word is captured into a separate parallel output register. It sits at the receive edge of a serial link and presents each word to downstream logic, which samples the parallel output between updates.

## Interface
Parameters:
- N, 8, word width and shift-register depth; legal range N >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- in  input  1  serial data bit, sampled on every rising clk edge when rst is low.
- out  output  N  live shift-register contents; updates every cycle.
- outP  output  N  last completed word; updates once per N sampled bits.

## Operation
- State:
  - Shift register sr[N-1:0], driving out.
  - Word register wr[N-1:0], driving outP.
  - Bit counter cnt, width $clog2(N), range 0..N-1.
- Reset (rst=1 at a rising edge): sr=0, wr=0, cnt=0. out=0 and outP=0 from that edge on.
- Each rising edge with rst=0:
  - sr <= {sr[N-2:0], in}: new bit enters the LSB and older bits move toward the MSB.
  - If cnt == N-1: wr <= {sr[N-2:0], in}, the same value sr takes on this edge; cnt <= 0.
  - Else cnt <= cnt+1.
- Bit order is MSB-first: the first bit sampled after reset ends up in outP[N-1], the Nth in outP[0].
- No enable and no idle state: every cycle out of reset consumes one bit. Words are back-to-back with no gap cycles.
- outP holds its value for exactly N cycles between updates.
- Reset mid-word discards the partial word: sr and cnt clear, and outP clears to 0. The next N bits form a fresh word.
- rst has priority over shifting on the same edge; the in value on that edge is dropped.

## Timing
- out latency: 1 cycle. The bit sampled at edge k is visible in out[0] after edge k.
- outP latency: the word completes at the Nth sampling edge after reset (or after the previous word). outP shows it after that same edge, with no extra pipeline stage.
- First outP update: at the Nth rising edge with rst=0 following reset.
- Counter wrap: N-1 -> 0 on the same edge wr loads, with no dead cycle.
- All outputs are registered; there are no combinational paths from in to out or outP.

## Structure
- No shared package is needed; N is the only configuration item, passed as a parameter.
- One natural sub-module, sipo_bit_counter: a modulo-N counter with a synchronous clear, emitting a word_done pulse when cnt==N-1.
- The top level holds sr, wr and the load logic.

## Test plan
- Reset: hold rst=1 for 2 cycles with in toggling -> out=8'h00, outP=8'h00 throughout; cnt=0.
- Alternating stream 1,0,1,0,... starting on the first edge after reset:
  - out=8'h01, 8'h02, 8'h05, 8'h0A, ... on successive edges.
  - At edge 8, outP=8'hAA, held through edge 15.
  - At edge 16, outP=8'hAA again.
- Back-to-back words: serial bits of 8'hA5 then 8'h3C, MSB first -> outP=8'hA5 after edge 8 and 8'h3C after edge 16; outP unchanged at edges 9-15.
- Mid-word reset: feed 5 bits of 8'hFF, assert rst for 1 cycle, then feed 8'h81 -> out=0 and outP=0 after the reset edge; outP=8'h81 exactly 8 edges after reset release.
- Word boundary with constant input: hold in=1 -> out fills 8'h01, 8'h03, ..., 8'hFF; outP stays 0 until edge 8, then becomes 8'hFF.
- Parameter check, N=4: stream 1,1,0,1,0,0,1,0 -> outP=4'hD after edge 4 and 4'h2 after edge 8.
